// File: rtl/ps2_key_events.sv
// PS/2 scan-code decoder: turns the raw byte stream into per-key held levels
// and one-cycle press/auto-repeat pulses for the game control FSMs.
module ps2_key_events #(
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [8:0] key_held,
  output logic [8:0] key_event
);

  // Terminal counts are one less than the period because the count starts
  // from 0 on the cycle the key becomes held.
  localparam logic [25:0] DELAY_LAST = 26'(REPEAT_DELAY - 32'd1);
  localparam logic [25:0] RATE_LAST  = 26'(REPEAT_RATE - 32'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        code_done_s;
  logic        ext_s, brk_s;
  logic [8:0]  key_mask_s, make_mask_s, break_mask_s, new_press_s;
  logic [2:0]  rep_hit_s, rep_pulse_s;
  logic [25:0] cnt_r [3];
  logic [2:0]  phase_r;

  function automatic logic [8:0] key_lookup(input logic [7:0] code, input logic ext);
    logic [8:0] mask;
    mask = 9'h000;
    if (ext) begin
      case (code)
        8'h6B:   mask = 9'h001;
        8'h74:   mask = 9'h002;
        8'h72:   mask = 9'h004;
        8'h75:   mask = 9'h008;
        default: mask = 9'h000;
      endcase
    end else begin
      case (code)
        8'h1C:   mask = 9'h001;
        8'h23:   mask = 9'h002;
        8'h1B:   mask = 9'h004;
        8'h1D:   mask = 9'h008;
        8'h5A:   mask = 9'h010;
        8'h66:   mask = 9'h020;
        8'h16:   mask = 9'h040;
        8'h1E:   mask = 9'h080;
        8'h26:   mask = 9'h100;
        default: mask = 9'h000;
      endcase
    end
    return mask;
  endfunction

  // Prefix FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Prefix FSM next state; code_done_s marks a non-prefix byte ending a sequence
  always_comb begin
    state_s     = state_r;
    code_done_s = 1'b0;
    if (received_data_en) begin
      case (state_r)
        IDLE: begin
          if (received_data == 8'hF0) begin
            state_s = BRK;
          end else if (received_data == 8'hE0) begin
            state_s = EXT;
          end else begin
            state_s     = IDLE;
            code_done_s = 1'b1;
          end
        end
        EXT: begin
          if (received_data == 8'hF0) begin
            state_s = EXT_BRK;
          end else if (received_data == 8'hE0) begin
            state_s = EXT;
          end else begin
            state_s     = IDLE;
            code_done_s = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          if ((received_data == 8'hF0) || (received_data == 8'hE0)) begin
            state_s = state_r;
          end else begin
            state_s     = IDLE;
            code_done_s = 1'b1;
          end
        end
        default: begin
          state_s     = IDLE;
          code_done_s = 1'b0;
        end
      endcase
    end else begin
      state_s     = state_r;
      code_done_s = 1'b0;
    end
  end

  // Key decode of a completed make/break and per-key repeat terminal count
  always_comb begin
    ext_s        = (state_r == EXT) || (state_r == EXT_BRK);
    brk_s        = (state_r == BRK) || (state_r == EXT_BRK);
    key_mask_s   = code_done_s ? key_lookup(received_data, ext_s) : 9'h000;
    make_mask_s  = brk_s ? 9'h000 : key_mask_s;
    break_mask_s = brk_s ? key_mask_s : 9'h000;
    new_press_s  = make_mask_s & ~key_held;
    rep_hit_s    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (key_held[k] && (cnt_r[k] == (phase_r[k] ? RATE_LAST : DELAY_LAST))) begin
        rep_hit_s[k] = 1'b1;
      end else begin
        rep_hit_s[k] = 1'b0;
      end
    end
    rep_pulse_s = rep_hit_s & ~break_mask_s[2:0];
  end

  // Auto-repeat counters for left/right/down; idle at zero whenever not held
  always_ff @(posedge CLOCK_50) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        cnt_r[k]   <= 26'd0;
        phase_r[k] <= 1'b0;
      end else if (break_mask_s[k] || !key_held[k]) begin
        cnt_r[k]   <= 26'd0;
        phase_r[k] <= 1'b0;
      end else if (rep_hit_s[k]) begin
        cnt_r[k]   <= 26'd0;
        phase_r[k] <= 1'b1;
      end else begin
        cnt_r[k]   <= cnt_r[k] + 26'd1;
        phase_r[k] <= phase_r[k];
      end
    end
  end

  // Registered held levels and event pulses
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_held  <= 9'h000;
      key_event <= 9'h000;
    end else begin
      key_held  <= (key_held | make_mask_s) & ~break_mask_s;
      key_event <= new_press_s | {6'b000000, rep_pulse_s};
    end
  end

endmodule

// File: tb/tb_ps2_key_events.sv
// Directed self-checking bench for ps2_key_events with REPEAT_DELAY=8, REPEAT_RATE=4.
module tb_ps2_key_events;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [8:0] key_held;
  logic [8:0] key_event;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ps2_key_events #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .key_held        (key_held),
    .key_event       (key_event)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic do_reset();
    reset = 1'b1;
    received_data_en = 1'b0;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
  endtask

  // One strobe captured at the next edge; outputs are sampled 1 time unit later
  task automatic strobe(input logic [7:0] b);
    received_data = b;
    received_data_en = 1'b1;
    @(posedge CLOCK_50); #1;
    received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK_50); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    received_data = 8'h00;
    received_data_en = 1'b0;
    idle(2);
    reset = 1'b0;
    total_cnt++; if (key_held !== 9'h000) $display("FAIL reset_held got %h want 000", key_held); else pass_cnt++;
    total_cnt++; if (key_event !== 9'h000) $display("FAIL reset_event got %h want 000", key_event); else pass_cnt++;
  endtask

  task automatic test_make_break();
    do_reset();
    strobe(8'h1C);
    total_cnt++; if (key_held !== 9'h001) $display("FAIL mb_held got %h want 001", key_held); else pass_cnt++;
    total_cnt++; if (key_event !== 9'h001) $display("FAIL mb_event got %h want 001", key_event); else pass_cnt++;
    idle(1);
    total_cnt++; if (key_event !== 9'h000) $display("FAIL mb_pulse_width got %h want 000", key_event); else pass_cnt++;
    strobe(8'hF0);
    total_cnt++; if (key_held !== 9'h001 || key_event !== 9'h000) $display("FAIL mb_prefix got %h/%h want 001/000", key_held, key_event); else pass_cnt++;
    strobe(8'h1C);
    total_cnt++; if (key_held !== 9'h000 || key_event !== 9'h000) $display("FAIL mb_break got %h/%h want 000/000", key_held, key_event); else pass_cnt++;
  endtask

  task automatic test_extended();
    do_reset();
    strobe(8'hE0);
    total_cnt++; if (key_held !== 9'h000 || key_event !== 9'h000) $display("FAIL ext_prefix got %h/%h want 000/000", key_held, key_event); else pass_cnt++;
    strobe(8'h75);
    total_cnt++; if (key_held !== 9'h008 || key_event !== 9'h008) $display("FAIL ext_make got %h/%h want 008/008", key_held, key_event); else pass_cnt++;
    strobe(8'hE0);
    strobe(8'hF0);
    total_cnt++; if (key_held !== 9'h008 || key_event !== 9'h000) $display("FAIL ext_brk_prefix got %h/%h want 008/000", key_held, key_event); else pass_cnt++;
    strobe(8'h75);
    total_cnt++; if (key_held !== 9'h000 || key_event !== 9'h000) $display("FAIL ext_break got %h/%h want 000/000", key_held, key_event); else pass_cnt++;
  endtask

  task automatic test_repeat();
    logic [8:0] exp;
    logic [8:0] seen;
    do_reset();
    strobe(8'h23);
    total_cnt++; if (key_event !== 9'h002) $display("FAIL rep_idx0 got %h want 002", key_event); else pass_cnt++;
    for (int i = 1; i < 30; i++) begin
      if (i == 5 || i == 14) strobe(8'h23);
      else idle(1);
      exp = (i >= 8 && ((i - 8) % 4) == 0) ? 9'h002 : 9'h000;
      total_cnt++; if (key_event !== exp) $display("FAIL rep_idx%0d got %h want %h", i, key_event, exp); else pass_cnt++;
    end
    total_cnt++; if (key_held !== 9'h002) $display("FAIL rep_held got %h want 002", key_held); else pass_cnt++;
    seen = 9'h000;
    strobe(8'hF0); seen |= key_event;
    strobe(8'h23); seen |= key_event;
    for (int i = 0; i < 10; i++) begin
      idle(1); seen |= key_event;
    end
    total_cnt++; if (seen !== 9'h000) $display("FAIL rep_suppressed got %h want 000", seen); else pass_cnt++;
    total_cnt++; if (key_held !== 9'h000) $display("FAIL rep_released got %h want 000", key_held); else pass_cnt++;
  endtask

  task automatic test_no_repeat_start();
    logic [8:0] seen;
    do_reset();
    strobe(8'h5A);
    total_cnt++; if (key_held !== 9'h010 || key_event !== 9'h010) $display("FAIL start_make got %h/%h want 010/010", key_held, key_event); else pass_cnt++;
    seen = 9'h000;
    for (int i = 0; i < 20; i++) begin
      idle(1); seen |= key_event;
    end
    total_cnt++; if (seen !== 9'h000) $display("FAIL start_no_repeat got %h want 000", seen); else pass_cnt++;
    strobe(8'hF0);
    strobe(8'h5A);
    total_cnt++; if (key_held !== 9'h000 || key_event !== 9'h000) $display("FAIL start_break got %h/%h want 000/000", key_held, key_event); else pass_cnt++;
  endtask

  task automatic test_reset_with_strobe();
    do_reset();
    strobe(8'hE0);
    received_data = 8'h1C;
    received_data_en = 1'b1;
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    received_data_en = 1'b0;
    reset = 1'b0;
    total_cnt++; if (key_held !== 9'h000 || key_event !== 9'h000) $display("FAIL rst_strobe got %h/%h want 000/000", key_held, key_event); else pass_cnt++;
    strobe(8'h1C);
    total_cnt++; if (key_held !== 9'h001 || key_event !== 9'h001) $display("FAIL rst_then_make got %h/%h want 001/001", key_held, key_event); else pass_cnt++;
  endtask

  task automatic test_alias();
    do_reset();
    strobe(8'h1C);
    total_cnt++; if (key_event !== 9'h001) $display("FAIL alias_first got %h want 001", key_event); else pass_cnt++;
    strobe(8'hE0);
    strobe(8'h6B);
    total_cnt++; if (key_held !== 9'h001 || key_event !== 9'h000) $display("FAIL alias_second got %h/%h want 001/000", key_held, key_event); else pass_cnt++;
    strobe(8'hF0);
    strobe(8'h1C);
    total_cnt++; if (key_held !== 9'h000) $display("FAIL alias_break got %h want 000", key_held); else pass_cnt++;
    strobe(8'h1C);
    strobe(8'h77);
    total_cnt++; if (key_held !== 9'h001 || key_event !== 9'h000) $display("FAIL unmapped got %h/%h want 001/000", key_held, key_event); else pass_cnt++;
  endtask

  task automatic test_concurrent();
    do_reset();
    strobe(8'h1C);
    idle(7);
    strobe(8'h23);
    total_cnt++; if (key_event !== 9'h003) $display("FAIL concurrent got %h want 003", key_event); else pass_cnt++;
    total_cnt++; if (key_held !== 9'h003) $display("FAIL concurrent_held got %h want 003", key_held); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    strobe(8'h1E);
    total_cnt++; if (key_event !== 9'h080) $display("FAIL b2b_first got %h want 080", key_event); else pass_cnt++;
    strobe(8'h26);
    total_cnt++; if (key_held !== 9'h180 || key_event !== 9'h100) $display("FAIL b2b_second got %h/%h want 180/100", key_held, key_event); else pass_cnt++;
    strobe(8'hF0);
    strobe(8'h1E);
    total_cnt++; if (key_held !== 9'h100) $display("FAIL b2b_break got %h want 100", key_held); else pass_cnt++;
    received_data = 8'h16;
    received_data_en = 1'b0;
    idle(2);
    total_cnt++; if (key_held !== 9'h100 || key_event !== 9'h000) $display("FAIL no_strobe got %h/%h want 100/000", key_held, key_event); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_repeat();
    test_no_repeat_start();
    test_reset_with_strobe();
    test_alias();
    test_concurrent();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
